// File: rtl/anc_pkg.sv
// Shared types and the 33-to-16-bit saturation helper for the ANC LMS datapath.
package anc_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [15:0] weight_t;
    typedef logic signed [31:0] prod_t;

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} lms_state_t;

    function automatic weight_t sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)
            return 16'sh7FFF;
        else if (v < -33'sd32768)
            return 16'sh8000;
        else
            return weight_t'(v[15:0]);
    endfunction

endpackage

// File: rtl/lms_weight_updater_if.sv
// Sample/error strobes, weight read port and status pulses of the LMS weight updater.
interface lms_weight_updater_if
    import anc_pkg::*;
    #(parameter int NUM_TAPS = 64);

    localparam int AW = $clog2(NUM_TAPS);

    sample_t         sample_in;
    logic            sample_ready_in;
    sample_t         error_in;
    logic            error_ready_in;
    logic            adapt_en_in;
    logic [AW-1:0]   coeff_addr_in;
    weight_t         coeff_out;
    logic            busy_out;
    logic            done_out;
    logic            sample_drop_out;
    logic            error_drop_out;

    modport master (
        output sample_in, sample_ready_in, error_in, error_ready_in,
               adapt_en_in, coeff_addr_in,
        input  coeff_out, busy_out, done_out, sample_drop_out, error_drop_out
    );

    modport slave (
        input  sample_in, sample_ready_in, error_in, error_ready_in,
               adapt_en_in, coeff_addr_in,
        output coeff_out, busy_out, done_out, sample_drop_out, error_drop_out
    );

endinterface

// File: rtl/lms_tap_mac.sv
// Combinational single-tap LMS update: w + ((e*x) >>> MU_SHIFT), saturated to 16 bits.
// With LMS_LEAKAGE_EN defined, the weight first decays by w >>> LEAK_SHIFT.
module lms_tap_mac
    import anc_pkg::*;
    #(
        parameter int MU_SHIFT   = 12,
        parameter int LEAK_SHIFT = 10
    ) (
        input  weight_t w,
        input  sample_t x,
        input  sample_t e,
        output weight_t w_next
    );

    if (MU_SHIFT < 0 || MU_SHIFT > 31) begin : g_bad_mu
        $error("MU_SHIFT must lie in 0..31");
    end
    if (LEAK_SHIFT < 0 || LEAK_SHIFT > 15) begin : g_bad_leak
        $error("LEAK_SHIFT must lie in 0..15");
    end

    prod_t              p;
    prod_t              d;
    logic signed [32:0] s;

    always_comb begin
        p = prod_t'(e) * prod_t'(x);
        d = p >>> MU_SHIFT;
`ifdef LMS_LEAKAGE_EN
        s = 33'(w) - 33'(w >>> LEAK_SHIFT) + 33'(d);
`else
        s = 33'(w) + 33'(d);
`endif
        w_next = sat16(s);
    end

endmodule

// File: rtl/lms_weight_updater.sv
// LMS weight updater: reference history, weight store and one-tap-per-cycle adaptation pass.
// Optional leakage is enabled by defining LMS_LEAKAGE_EN (see lms_tap_mac).
module lms_weight_updater
    import anc_pkg::*;
    #(
        parameter int NUM_TAPS   = 64,
        parameter int MU_SHIFT   = 12,
        parameter int LEAK_SHIFT = 10
    ) (
        input  logic                 clk_in,
        input  logic                 rst_n_in,
        lms_weight_updater_if.slave  bus
    );

    localparam int            AW   = $clog2(NUM_TAPS);
    localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);

    if (NUM_TAPS < 4 || (NUM_TAPS & (NUM_TAPS - 1)) != 0) begin : g_bad_taps
        $error("NUM_TAPS must be a power of two and at least 4");
    end

    lms_state_t    state;
    logic [AW-1:0] k;
    logic [AW-1:0] base;
    logic [AW-1:0] wp;
    logic [AW-1:0] wp_plus1;
    logic [AW-1:0] x_idx;
    sample_t       e_lat;
    sample_t       pend;
    logic          pend_valid;
    sample_t       hist [NUM_TAPS];
    weight_t       w    [NUM_TAPS];
    weight_t       w_next;

    // Newest sample sits just below the write pointer latched at pass start.
    assign x_idx    = base - AW'(1) - k;
    assign wp_plus1 = wp + AW'(1);

    lms_tap_mac #(
        .MU_SHIFT   (MU_SHIFT),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_mac (
        .w      (w[k]),
        .x      (hist[x_idx]),
        .e      (e_lat),
        .w_next (w_next)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            k          <= '0;
            base       <= '0;
            wp         <= '0;
            e_lat      <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                hist[i] <= '0;
                w[i]    <= '0;
            end
            bus.coeff_out       <= '0;
            bus.busy_out        <= 1'b0;
            bus.done_out        <= 1'b0;
            bus.sample_drop_out <= 1'b0;
            bus.error_drop_out  <= 1'b0;
        end else begin
            bus.coeff_out       <= w[bus.coeff_addr_in];
            bus.done_out        <= 1'b0;
            bus.sample_drop_out <= 1'b0;
            bus.error_drop_out  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.sample_ready_in) begin
                        hist[wp] <= bus.sample_in;
                        wp       <= wp_plus1;
                    end
                    if (bus.error_ready_in && bus.adapt_en_in) begin
                        e_lat        <= bus.error_in;
                        k            <= '0;
                        base         <= wp;
                        state        <= UPDATE;
                        bus.busy_out <= 1'b1;
                    end
                end

                UPDATE: begin
                    w[k] <= w_next;
                    k    <= k + AW'(1);
                    if (bus.sample_ready_in) begin
                        pend       <= bus.sample_in;
                        pend_valid <= 1'b1;
                        if (pend_valid)
                            bus.sample_drop_out <= 1'b1;
                    end
                    if (bus.error_ready_in)
                        bus.error_drop_out <= 1'b1;
                    if (k == LAST) begin
                        state        <= DONE;
                        bus.done_out <= 1'b1;
                    end
                end

                DONE: begin
                    // Pending sample is older than any same-cycle arrival, so it lands first.
                    if (pend_valid && bus.sample_ready_in) begin
                        hist[wp]       <= pend;
                        hist[wp_plus1] <= bus.sample_in;
                        wp             <= wp + AW'(2);
                    end else if (pend_valid) begin
                        hist[wp] <= pend;
                        wp       <= wp_plus1;
                    end else if (bus.sample_ready_in) begin
                        hist[wp] <= bus.sample_in;
                        wp       <= wp_plus1;
                    end
                    pend_valid <= 1'b0;
                    if (bus.error_ready_in)
                        bus.error_drop_out <= 1'b1;
                    state        <= IDLE;
                    bus.busy_out <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    bus.busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lms_weight_updater.md
# lms_weight_updater

Consumer of the error-sample stream: on each error strobe it performs one LMS adaptation pass over the anti-noise FIR weights, w[k] += (e·x[n−k]) >>> MU_SHIFT, and serves the weights to the filter through a registered read port. It sits between the error calculator and the anti-noise FIR. It owns the reference-sample history and the weight store.

## Interface
- NUM_TAPS, 64: number of FIR weights and history depth; power of two, at least 4.
- MU_SHIFT, 12: step size mu = 2^−MU_SHIFT, applied as an arithmetic right shift.
- LEAK_SHIFT, 10: leakage shift; used only with LMS_LEAKAGE_EN.
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- sample_in  in  16  signed reference (ambient mic) sample.
- sample_ready_in  in  1  one-cycle strobe; sample_in valid.
- error_in  in  16  signed error sample.
- error_ready_in  in  1  one-cycle strobe; error_in valid.
- adapt_en_in  in  1  adaptation enable (noise cancel on).
- coeff_addr_in  in  $clog2(NUM_TAPS)  weight read address.
- coeff_out  out  16  signed weight at coeff_addr_in, registered.
- busy_out  out  1  adaptation pass in progress.
- done_out  out  1  one-cycle pulse at the end of a pass.
- sample_drop_out  out  1  one-cycle pulse when a pending sample is overwritten.
- error_drop_out  out  1  one-cycle pulse when an error strobe is ignored because the block is busy.

## Operation
- History: circular buffer of NUM_TAPS samples with write pointer wp. A sample write stores to buf[wp], then wp++ (wraps). x[n−k] = buf[(wp−1−k) mod NUM_TAPS].
- FSM states are IDLE, UPDATE and DONE.
  - IDLE → UPDATE on error_ready_in && adapt_en_in. On that transition latch e = error_in, set k = 0 and base = wp.
  - UPDATE: one tap per cycle, k = 0..NUM_TAPS−1. After tap NUM_TAPS−1, go to DONE.
  - DONE: pulse done_out, commit any pending sample, return to IDLE.
- Tap arithmetic:
  - p = e·x is a 32-bit signed product.
  - d = p >>> MU_SHIFT, an arithmetic shift (rounds toward −inf).
  - s = w[k] + d is computed at 33 bits, then saturated to [−32768, 32767].
  - The write-back to w[k] happens on the same edge.
- Samples in IDLE are written immediately. Samples in UPDATE or DONE go to a one-entry pending register, committed in DONE.
  - A second sample while the pending register is full overwrites it and pulses sample_drop_out.
  - A pending sample plus a same-cycle new sample in DONE: commit pending to buf[wp] and the new sample to buf[wp+1]; wp advances by 2.
- error_ready_in while not in IDLE: ignored, and error_drop_out pulses. error_ready_in with adapt_en_in low: ignored, no pulse.
- adapt_en_in falling mid-pass: the pass completes.
- Reset: all weights 0, history 0, wp 0, pending empty, FSM IDLE. busy_out, done_out, sample_drop_out, error_drop_out and coeff_out are all 0. A reset mid-pass aborts immediately.

## Timing
- Error strobe in cycle 0 → busy_out high in cycles 1..NUM_TAPS+1 → done_out high in cycle NUM_TAPS+1 only. The block accepts the next strobe in cycle NUM_TAPS+2.
- Tap k is written at the end of cycle k+1.
- coeff_out = w[coeff_addr_in] one cycle after the address. It reflects all writes up to the previous edge, so a read mid-pass may return mixed old and new weights.
- Sample write latency is 1 cycle in IDLE.

## Configuration
- LMS_LEAKAGE_EN defined: s = w[k] − (w[k] >>> LEAK_SHIFT) + d, saturated as above. Weights decay toward 0 under zero error.
- LMS_LEAKAGE_EN undefined: pure LMS. With zero error the weights are bit-exact constant; LEAK_SHIFT is unused.

## Structure
- Package anc_pkg holds:
  - sample_t and weight_t (signed 16-bit) and prod_t (signed 32-bit);
  - the lms_state_t enum {IDLE, UPDATE, DONE};
  - sat16(), which saturates 33-bit to 16-bit.
- Sub-module lms_tap_mac is combinational. Inputs are w, x and e; output is the saturated updated weight, with leakage under the macro.
- History and weights are flop arrays; no RAM inference is required.

## Test plan
Tests use NUM_TAPS=8 and MU_SHIFT=4 unless stated.
- Reset check: assert rst_n_in low mid-pass → busy_out, done_out and every w read via coeff_out are 0 in the next cycle; after release, strobes are accepted normally.
- Basic pass: push samples 1..8, then error 16 → w[0]=8 and w[7]=1; done_out exactly 9 cycles after the strobe; busy_out for 9 cycles.
- Rounding: x all 1, e=−1 → every w = −1. Repeat 3 passes → −3.
- Saturation: MU_SHIFT=0, x=32767, e=32767 → all w=32767; then e=−32768 twice → w=−32768, with no wrap.
- Busy collisions: two samples (5, 9) during UPDATE → one sample_drop_out pulse; after done_out, x[n]=9 and 5 is absent. An error strobe during UPDATE → error_drop_out pulse and weights unchanged by it.
- Enable and leakage: adapt_en_in=0 with strobe e=100 → no busy_out, weights unchanged. With LMS_LEAKAGE_EN, LEAK_SHIFT=2, w=64, e=0 → w=48 after one pass.
